// File: rtl/max_pool_2x2_ctrl_if.sv
// Bus bundle between the 2x2 max-pool scheduler and its surroundings:
// frame control, pixel stream, pooling-datapath window/result and status.
interface max_pool_2x2_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIM_W = 6
);
  logic                    start;
  logic [DIM_W-1:0]        cfg_width;
  logic [DIM_W-1:0]        cfg_height;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic signed [WIDTH-1:0] pool_a;
  logic signed [WIDTH-1:0] pool_b;
  logic signed [WIDTH-1:0] pool_c;
  logic signed [WIDTH-1:0] pool_d;
  logic signed [WIDTH-1:0] pool_dout;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic                    busy;
  logic                    done;
  logic                    err;

  // Environment side: drives frames/pixels and hosts the pooling datapath.
  modport master (
    output start, cfg_width, cfg_height, in_valid, in_data, pool_dout,
    input  in_ready, pool_a, pool_b, pool_c, pool_d, out_valid, out_data,
           busy, done, err
  );

  // Controller side.
  modport slave (
    input  start, cfg_width, cfg_height, in_valid, in_data, pool_dout,
    output in_ready, pool_a, pool_b, pool_c, pool_d, out_valid, out_data,
           busy, done, err
  );
endinterface

// File: rtl/max_pool_2x2_ctrl.sv
// Streaming scheduler for a 2x2 max-pool datapath: buffers even rows,
// issues one window per odd-row/odd-column pixel, tracks datapath latency
// to strobe each pooled result, and pulses done at end of frame.
module max_pool_2x2_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX_W = 32,
  parameter int unsigned DIM_W = 6,
  parameter int unsigned LAT   = 2
) (
  input logic                clk,
  input logic                rst,
  max_pool_2x2_ctrl_if.slave bus
);
  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state;
  logic [1:0]              state_nx;
  logic [DIM_W-1:0]        w_q;
  logic [DIM_W-1:0]        h_q;
  logic [DIM_W-1:0]        row;
  logic [DIM_W-1:0]        col;
  logic [DIM_W-1:0]        row_lim;
  logic [DIM_W-1:0]        col_lim;
  logic signed [WIDTH-1:0] linebuf [MAX_W];
  logic signed [WIDTH-1:0] prev_px;
  logic signed [WIDTH-1:0] pool_a_q;
  logic signed [WIDTH-1:0] pool_b_q;
  logic signed [WIDTH-1:0] pool_c_q;
  logic signed [WIDTH-1:0] pool_d_q;
  logic                    iss;
  logic [LAT-1:0]          dly;
  logic                    in_ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic cfg_bad;
  logic start_ok;
  logic accept;
  logic col_wrap;
  logic last_px;
  logic issue;
  logic pipe_empty;

  // Frame/pixel qualifiers; limits are the last odd index of the pooled area.
  assign cfg_bad    = (bus.cfg_width < DIM_W'(2)) || (bus.cfg_height < DIM_W'(2)) ||
                      (bus.cfg_width > DIM_W'(MAX_W));
  assign start_ok   = (state == S_IDLE) && bus.start && !cfg_bad;
  assign accept     = bus.in_valid && in_ready_q;
  assign col_wrap   = (col == w_q - DIM_W'(1));
  assign last_px    = col_wrap && (row == h_q - DIM_W'(1));
  assign row_lim    = {h_q[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign col_lim    = {w_q[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign issue      = accept && row[0] && col[0] && (row <= row_lim) && (col <= col_lim);
  assign pipe_empty = !iss && (dly == '0);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_RUN;
      S_RUN:   if (accept && last_px) state_nx = S_DRAIN;
      S_DRAIN: if (pipe_empty) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx == S_RUN);
      busy_q     <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      done_q     <= (state_nx == S_DONE);
      err_q      <= (state == S_IDLE) && bus.start && cfg_bad;
    end
  end

  // Frame geometry latch and raster position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= '0;
      h_q <= '0;
      row <= '0;
      col <= '0;
    end else if (start_ok) begin
      w_q <= bus.cfg_width;
      h_q <= bus.cfg_height;
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  // Even-row line buffer; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (accept && !row[0]) linebuf[AW'(col)] <= bus.in_data;
  end

  // Odd-row previous pixel, window issue and latency tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_px  <= '0;
      pool_a_q <= '0;
      pool_b_q <= '0;
      pool_c_q <= '0;
      pool_d_q <= '0;
      iss      <= 1'b0;
      dly      <= '0;
    end else begin
      iss <= issue;
      dly <= LAT'({dly, iss});
      if (accept && row[0]) prev_px <= bus.in_data;
      if (issue) begin
        pool_a_q <= linebuf[AW'(col - DIM_W'(1))];
        pool_b_q <= linebuf[AW'(col)];
        pool_c_q <= prev_px;
        pool_d_q <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.pool_a    = pool_a_q;
  assign bus.pool_b    = pool_b_q;
  assign bus.pool_c    = pool_c_q;
  assign bus.pool_d    = pool_d_q;
  assign bus.out_valid = dly[LAT-1];
  assign bus.out_data  = bus.pool_dout;
endmodule

// File: tb/tb_max_pool_2x2_ctrl.sv
// Self-checking bench for max_pool_2x2_ctrl: hosts a LAT-stage max datapath,
// drives directed and random frames and compares against a window model.
module tb_max_pool_2x2_ctrl;
  localparam int WIDTH = 8;
  localparam int MAX_W = 32;
  localparam int DIM_W = 6;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  max_pool_2x2_ctrl_if #(.WIDTH(WIDTH), .DIM_W(DIM_W)) bus ();

  max_pool_2x2_ctrl #(.WIDTH(WIDTH), .MAX_W(MAX_W), .DIM_W(DIM_W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External pooling datapath: LAT register stages from pool_a..d to pool_dout.
  function automatic logic signed [WIDTH-1:0] max4(input logic signed [WIDTH-1:0] a, b, c, d);
    logic signed [WIDTH-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  logic signed [WIDTH-1:0] s0, s1;
  always @(posedge clk) begin
    s0 <= max4(bus.pool_a, bus.pool_b, bus.pool_c, bus.pool_d);
    s1 <= s0;
  end
  assign bus.pool_dout = s1;

  // Output monitor, sampled away from the active edge.
  int got_q[$];
  int got_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int err_cnt  = 0;
  int upd_cnt  = 0;
  logic [4*WIDTH-1:0] pool_prev = '0;
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      got_q.push_back(int'(bus.out_data));
      got_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (bus.err === 1'b1) err_cnt = err_cnt + 1;
    if ({bus.pool_a, bus.pool_b, bus.pool_c, bus.pool_d} !== pool_prev) upd_cnt = upd_cnt + 1;
    pool_prev = {bus.pool_a, bus.pool_b, bus.pool_c, bus.pool_d};
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  int pix[$];

  // Present one pixel and wait (bounded) for it to be accepted; returns accept edge index.
  task automatic drive_px(input int v, output int acc_cyc);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(v);
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("accept_timeout", guard, 0);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  // Run one frame from pix[], model expected windows and their strobe cycles, then compare.
  task automatic run_frame(input string tag, input int w, input int h, input bit gaps,
                           input bit inj_start, input bit chk_upd);
    int exp_q[$];
    int exp_c[$];
    int acc;
    int guard;
    int idx;
    got_q.delete();
    got_cyc.delete();
    done_cnt = 0;
    err_cnt  = 0;
    check({tag, "_idle_ready"}, bus.in_ready, 0);
    bus.start      = 1'b1;
    bus.cfg_width  = DIM_W'(w);
    bus.cfg_height = DIM_W'(h);
    @(negedge clk);
    bus.start = 1'b0;
    upd_cnt   = 0;
    check({tag, "_run_ready"}, bus.in_ready, 1);
    check({tag, "_run_busy"}, bus.busy, 1);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        idx = r * w + c;
        if (gaps) begin
          bus.in_valid = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        if (inj_start && idx == 5) begin
          bus.start     = 1'b1;
          bus.cfg_width = DIM_W'(1);
        end
        drive_px(pix[idx], acc);
        bus.start     = 1'b0;
        bus.cfg_width = DIM_W'(w);
        if ((r % 2 == 1) && (c % 2 == 1) && (r < (h / 2) * 2) && (c < (w / 2) * 2)) begin
          exp_q.push_back(int'(max4(WIDTH'(pix[idx - w - 1]), WIDTH'(pix[idx - w]),
                                    WIDTH'(pix[idx - 1]), WIDTH'(pix[idx]))));
          exp_c.push_back(acc + LAT);
        end
      end
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done_seen"}, (guard < 50) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_n_results"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s_cyc%0d", tag, i), got_cyc[i], exp_c[i]);
    end
    if (got_cyc.size() > 0)
      check({tag, "_done_after_last"}, (done_cyc > got_cyc[got_cyc.size()-1]) ? 1 : 0, 1);
    check({tag, "_no_err"}, err_cnt, 0);
    check({tag, "_end_ready"}, bus.in_ready, 0);
    check({tag, "_end_busy"}, bus.busy, 0);
    if (chk_upd) check({tag, "_pool_updates"}, upd_cnt, exp_q.size());
  endtask

  task automatic bad_start(input string tag, input int w, input int h);
    err_cnt = 0;
    bus.start      = 1'b1;
    bus.cfg_width  = DIM_W'(w);
    bus.cfg_height = DIM_W'(h);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_err"}, bus.err, 1);
    check({tag, "_ready"}, bus.in_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    @(negedge clk);
    check({tag, "_err_pulse"}, bus.err, 0);
    check({tag, "_still_idle"}, bus.in_ready, 0);
  endtask

  task automatic ramp(input int n, input int base);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(base + i);
  endtask

  task automatic rand_pix(input int n);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(int'($urandom_range(0, 255)) - 128);
  endtask

  initial begin
    int acc;
    int rw;
    int rh;
    bus.start      = 1'b0;
    bus.cfg_width  = '0;
    bus.cfg_height = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;

    // Reset values.
    @(negedge clk);
    check("rst_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pool_a", bus.pool_a, 0);
    check("rst_pool_d", bus.pool_d, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 4x4 ramp, continuous valid.
    ramp(16, 0);
    run_frame("f4x4", 4, 4, 1'b0, 1'b0, 1'b1);

    // 4x2 negative pixels, signed compare.
    pix = '{-1, -8, -3, -2, -128, -5, -7, -6};
    run_frame("f4x2neg", 4, 2, 1'b0, 1'b0, 1'b1);

    // 5x3, odd dimensions floor away last column and row.
    ramp(15, 1);
    run_frame("f5x3", 5, 3, 1'b0, 1'b0, 1'b1);

    // 4x4 ramp with random valid gaps.
    ramp(16, 0);
    run_frame("f4x4gap", 4, 4, 1'b1, 1'b0, 1'b1);

    // Rejected starts.
    bad_start("bad_w1", 1, 4);
    bad_start("bad_wmax", MAX_W + 1, 4);
    bad_start("bad_h1", 4, 1);

    // Start during RUN is ignored.
    ramp(16, 0);
    run_frame("f4x4inj", 4, 4, 1'b0, 1'b1, 1'b1);

    // Widest legal frame and random frames.
    rand_pix(MAX_W * 2);
    run_frame("fmaxw", MAX_W, 2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rw = $urandom_range(2, 9);
      rh = $urandom_range(2, 7);
      rand_pix(rw * rh);
      run_frame($sformatf("frand%0d", k), rw, rh, 1'b1, 1'b0, 1'b0);
    end

    // Reset one cycle after issuing the window ending at pixel 13.
    ramp(16, 0);
    got_q.delete();
    bus.start      = 1'b1;
    bus.cfg_width  = DIM_W'(4);
    bus.cfg_height = DIM_W'(4);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i <= 13; i++) drive_px(pix[i], acc);
    bus.in_valid = 1'b0;
    @(negedge clk);
    got_q.delete();
    rst = 1'b1;
    #1;
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_pool_a", bus.pool_a, 0);
    check("mrst_pool_b", bus.pool_b, 0);
    check("mrst_pool_c", bus.pool_c, 0);
    check("mrst_pool_d", bus.pool_d, 0);
    check("mrst_ready", bus.in_ready, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_no_out_valid", got_q.size(), 0);
    ramp(16, 0);
    run_frame("f4x4post", 4, 4, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
